// File: rtl/sensors_pkg.sv
// Shared types and width helpers for the sensor aggregator and its divider.
package sensors_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DIV, OUT} state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  localparam int NUM_SENSORS_DEF = 4;
  localparam int W_DEF           = 8;
  localparam int SUM_W           = W_DEF + clog2(NUM_SENSORS_DEF);
  localparam int CNT_W           = clog2(NUM_SENSORS_DEF + 1);

endpackage

// File: rtl/sensors_aggregator_if.sv
// Sample-in / result-out handshake bundle between the sensor front-end and the aggregator.
interface sensors_aggregator_if #(
  parameter int NUM_SENSORS = 4,
  parameter int W           = 8,
  parameter int CNT_W       = 3
);
  logic                     in_valid;
  logic                     in_ready;
  logic [NUM_SENSORS*W-1:0] sensors;
  logic                     out_valid;
  logic                     out_ready;
  logic [W-1:0]             height;
  logic [CNT_W-1:0]         valid_count;
  logic                     err_no_valid;
  logic                     err_low_conf;

  modport master (
    output in_valid, sensors, out_ready,
    input  in_ready, out_valid, height, valid_count, err_no_valid, err_low_conf
  );

  modport slave (
    input  in_valid, sensors, out_ready,
    output in_ready, out_valid, height, valid_count, err_no_valid, err_low_conf
  );
endinterface

// File: rtl/seq_divider.sv
// Unsigned restoring divider: loads on start, one quotient bit per cycle for DW cycles.
// done_o/quotient_o are valid combinationally in the final iteration cycle; divisor 0 yields 0.
module seq_divider
  import sensors_pkg::*;
#(
  parameter int DW = 10,
  parameter int VW = 3,
  parameter int QW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [DW-1:0] dividend_i,
  input  logic [VW-1:0] divisor_i,
  output logic          done_o,
  output logic [QW-1:0] quotient_o
);
  localparam int STW = (clog2(DW) < 1) ? 1 : clog2(DW);

  logic           busy_q;
  logic [STW-1:0] step_q;
  logic [DW-1:0]  rem_q, rem_d;
  logic [DW-1:0]  quo_q, quo_d;
  logic [VW-1:0]  dvs_q;
  logic [DW:0]    trial;
  logic           take;

  // Gating on a non-zero divisor makes every quotient bit 0 for divide-by-zero.
  always_comb begin
    trial = {rem_q, quo_q[DW-1]};
    take  = (dvs_q != '0) && (trial >= (DW+1)'(dvs_q));
    rem_d = take ? (trial[DW-1:0] - DW'(dvs_q)) : trial[DW-1:0];
    quo_d = {quo_q[DW-2:0], take};
  end

  assign done_o     = busy_q && (step_q == STW'(DW-1));
  assign quotient_o = quo_d[QW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      step_q <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      step_q <= '0;
      rem_q  <= '0;
      quo_q  <= dividend_i;
      dvs_q  <= divisor_i;
    end else if (busy_q) begin
      busy_q <= !done_o;
      step_q <= step_q + 1'b1;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
    end
  end
endmodule

// File: rtl/sensors_aggregator.sv
// Captures N readings, averages the non-zero ones (round half up) with a fixed-latency
// sequential divide, and holds the result with confidence flags until the consumer accepts it.
module sensors_aggregator
  import sensors_pkg::*;
#(
  parameter int NUM_SENSORS = 4,
  parameter int W           = 8,
  parameter int MIN_VALID   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sensors_aggregator_if.slave  bus
);
  localparam int SW   = W + clog2(NUM_SENSORS);
  localparam int CW   = clog2(NUM_SENSORS + 1);
  localparam int IW   = (clog2(NUM_SENSORS) < 1) ? 1 : clog2(NUM_SENSORS);

  state_t                   state_q, state_d;
  logic [NUM_SENSORS*W-1:0] sample_q, sample_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [SW-1:0]            sum_q, sum_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [W-1:0]             height_q, height_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     nov_q, nov_d;
  logic                     low_q, low_d;
  logic [W-1:0]             reading;
  logic                     div_start, div_done;
  logic [SW-1:0]            dividend;
  logic [W-1:0]             div_quot;

  always_comb begin
    state_d   = state_q;
    sample_d  = sample_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    height_d  = height_q;
    count_d   = count_q;
    nov_d     = nov_q;
    low_d     = low_q;
    div_start = 1'b0;
    reading   = sample_q[idx_q*W +: W];
    case (state_q)
      IDLE: if (bus.in_valid) begin
        sample_d = bus.sensors;
        idx_d    = '0;
        sum_d    = '0;
        cnt_d    = '0;
        state_d  = ACCUM;
      end
      ACCUM: begin
        if (reading != '0) begin
          sum_d = sum_q + SW'(reading);
          cnt_d = cnt_q + 1'b1;
        end
        idx_d = idx_q + 1'b1;
        // Divider is loaded with the final sum on the same edge as the last add.
        if (idx_q == IW'(NUM_SENSORS - 1)) begin
          div_start = 1'b1;
          state_d   = DIV;
        end
      end
      DIV: if (div_done) begin
        height_d = div_quot;
        count_d  = cnt_q;
        nov_d    = (cnt_q == '0);
        low_d    = (int'(cnt_q) < MIN_VALID);
        state_d  = OUT;
      end
      OUT: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign dividend = sum_d + SW'(cnt_d >> 1);

  seq_divider #(.DW(SW), .VW(CW), .QW(W)) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (div_start),
    .dividend_i (dividend),
    .divisor_i  (cnt_d),
    .done_o     (div_done),
    .quotient_o (div_quot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sample_q <= '0;
      idx_q    <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      height_q <= '0;
      count_q  <= '0;
      nov_q    <= 1'b0;
      low_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      idx_q    <= idx_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      height_q <= height_d;
      count_q  <= count_d;
      nov_q    <= nov_d;
      low_q    <= low_d;
    end
  end

  assign bus.in_ready     = (state_q == IDLE);
  assign bus.out_valid    = (state_q == OUT);
  assign bus.height       = height_q;
  assign bus.valid_count  = count_q;
  assign bus.err_no_valid = nov_q;
  assign bus.err_low_conf = low_q;
endmodule
